prog_mem_loader: RTL and testbench
==================================

Name: prog_mem_loader

Overview:
- 16x8 program memory serving the 4-bit CPU's instruction fetch (CPU drives `adr`, block returns `dout`).
- Byte-stream loader writes a new program while the CPU is held in reset.
- Owns CPU run control: drives `cpu_run`, which connects to the CPU's active-low `reset`.
- Sits between the board-level loader source (serial bridge or button sequencer) and the CPU.

Parameters:
- ADDR_W, 4, fetch address width; memory depth = 2**ADDR_W.
- DATA_W, 8, instruction width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- adr  in  ADDR_W  CPU fetch address (CPU PC).
- dout  out  DATA_W  instruction at `adr`.
- load_req  in  1  request to reload the program; single-cycle pulse or level.
- in_valid  in  1  loader byte valid.
- in_data  in  DATA_W  loader byte.
- in_ready  out  1  block accepts a byte this cycle.
- cpu_run  out  1  1 = CPU released; 0 = CPU held in reset.
- busy  out  1  high in CLEAR or LOAD.
- checksum  out  DATA_W  mod-256 sum of bytes accepted in the last load.

Behaviour:
- Reset (synchronous, active-high) wins over every other input.
  - state = CLEAR, ptr = 0, cpu_run = 0, in_ready = 0, busy = 1, checksum = 0, pend = 0.
- States: CLEAR, RUN, LOAD.
- CLEAR:
  - Writes mem[ptr] = 8'h00 (MOV r0,r0, i.e. NOP) each cycle; ptr increments.
  - Takes exactly 16 cycles (ptr 0..15).
  - After the ptr = 15 write: go to LOAD if pend = 1, otherwise RUN. ptr = 0.
  - load_req seen during CLEAR sets pend; it is not lost.
- RUN:
  - cpu_run = 1 in the cycle after entry (registered); busy = 0; in_ready = 0.
  - in_valid is ignored.
  - load_req = 1 -> LOAD next cycle, and cpu_run = 0 next cycle.
- LOAD:
  - Entry: ptr = 0, checksum cleared to 0, pend cleared.
  - in_ready = 1 (registered, asserted from the first LOAD cycle).
  - Each cycle with in_valid & in_ready: mem[ptr] = in_data, checksum = checksum + in_data (wraps mod 256), ptr++.
  - Acceptance of the 16th byte (ptr = 15): in_ready drops to 0 the next cycle, state -> RUN, cpu_run rises one cycle later.
  - load_req during LOAD is ignored (no restart).
  - in_valid low: wait indefinitely; no timeout.
- Read path:
  - dout = mem[adr], combinational (asynchronous read).
  - The CPU samples dout at the same clk edge at which it updates adr, so zero-latency read is required.
  - dout reflects writes from the cycle after the write edge.
  - During LOAD, dout may return partially loaded contents; harmless because cpu_run = 0.
- cpu_run must never be 1 while state is CLEAR or LOAD.
  - Drop to 0 is registered on the same edge as the transition into LOAD.
  - The CPU therefore executes at most the instruction fetched in the load_req cycle.
- ptr wrap: ptr is ADDR_W bits. Exactly 16 bytes per load; extra bytes arrive only in RUN and are ignored.
- Simultaneous load_req and reset: reset wins; load_req in that cycle is dropped.
- Reset mid-LOAD: full CLEAR again; memory becomes all 8'h00; checksum = 0.

Decomposition:
- Shared package `cpu_pkg`:
  - ADDR_W and DATA_W constants.
  - Enum `loader_state_t` {CLEAR, RUN, LOAD}.
  - NOP opcode constant 8'h00.
- One sub-module `prog_ram`:
  - 16x8 register array, 1 write port (we, waddr, wdata), 1 asynchronous read port.
  - Infers distributed RAM.
- FSM, ptr, checksum and handshake logic live in the top.

Test Plan:
- Reset released, no load_req -> busy = 1 for 16 cycles, then cpu_run = 1 on cycle 17; dout = 8'h00 for all adr 0..15.
- load_req in RUN, stream 16 bytes back-to-back (8'hA3, 8'h90, 8'h00…) -> cpu_run = 0 on the next edge; mem[0] = 8'hA3, mem[1] = 8'h90; checksum = 8'h33; cpu_run = 1 two cycles after the last accept.
- Same load with in_valid toggling 1-0-1 each cycle -> 16 bytes accepted over 31 cycles; identical memory contents; in_ready stays 1 throughout LOAD.
- Sixteen bytes of 8'hFF -> checksum = 8'hF0 (wrap check); dout at adr = 4'hF is 8'hFF.
- load_req pulsed in cycle 5 of CLEAR -> LOAD entered right after CLEAR; cpu_run never goes high in between.
- Reset asserted after 7 bytes of a load -> CLEAR; afterwards all locations read 8'h00, checksum = 0, cpu_run = 1 at 17 cycles after reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the 4-bit CPU program memory and its loader.
package cpu_pkg;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 2 ** ADDR_W;

    // MOV r0,r0 -- the CPU's do-nothing instruction, used to blank memory.
    localparam logic [DATA_W-1:0] NOP = 8'h00;

    typedef enum logic [1:0] {
        CLEAR,
        RUN,
        LOAD
    } loader_state_t;

endpackage

// File: rtl/prog_mem_loader_if.sv
// Bus between the CPU/loader source side and the program memory loader.
interface prog_mem_loader_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
);
    import cpu_pkg::*;

    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dout;
    logic              load_req;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              cpu_run;
    logic              busy;
    logic [DATA_W-1:0] checksum;

    // The loader block itself.
    modport slave (
        input  adr, load_req, in_valid, in_data,
        output dout, in_ready, cpu_run, busy, checksum
    );

    // CPU fetch port plus the board-level byte source.
    modport master (
        output adr, load_req, in_valid, in_data,
        input  dout, in_ready, cpu_run, busy, checksum
    );

endinterface

// File: rtl/prog_ram.sv
// 16x8 program store: one synchronous write port, one asynchronous read port.
module prog_ram #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    import cpu_pkg::*;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port. NOTE: the array has no reset term so it maps to distributed
    // RAM; the loader's CLEAR sweep is what blanks it after reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Zero-latency read: the CPU samples dout on the same edge it moves adr.
    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_mem_loader.sv
// Program memory for the 4-bit CPU plus a byte-stream loader that owns the
// CPU's run control. After reset memory is swept to NOP; a load request holds
// the CPU in reset while exactly 2**ADDR_W bytes are written in order.
module prog_mem_loader #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    prog_mem_loader_if.slave bus
);
    import cpu_pkg::*;

    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    loader_state_t     state, state_next;
    logic [ADDR_W-1:0] ptr, ptr_next;
    logic              pend, pend_next;
    logic [DATA_W-1:0] checksum, checksum_next;
    logic              cpu_run;
    logic              in_ready;
    logic              accept;
    logic              we;
    logic [DATA_W-1:0] wdata;

    assign accept = bus.in_valid & in_ready;

    // Next-state, pointer, checksum and write-port decode.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_next    = state;
        ptr_next      = ptr;
        pend_next     = pend;
        checksum_next = checksum;
        we            = 1'b0;
        wdata         = NOP;

        unique case (state)
            CLEAR: begin
                we       = 1'b1;
                wdata    = NOP;
                ptr_next = ptr + 1'b1;
                // A reload asked for mid-sweep is remembered, not dropped.
                if (bus.load_req) begin
                    pend_next = 1'b1;
                end
                if (ptr == PTR_LAST) begin
                    ptr_next = '0;
                    if (pend || bus.load_req) begin
                        state_next    = LOAD;
                        checksum_next = '0;
                        pend_next     = 1'b0;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.load_req) begin
                    state_next    = LOAD;
                    ptr_next      = '0;
                    checksum_next = '0;
                    pend_next     = 1'b0;
                end
            end
            LOAD: begin
                // load_req is deliberately ignored here: no restart mid-load.
                if (accept) begin
                    we            = 1'b1;
                    wdata         = bus.in_data;
                    checksum_next = checksum + bus.in_data;
                    ptr_next      = ptr + 1'b1;
                    if (ptr == PTR_LAST) begin
                        state_next = RUN;
                    end
                end
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // State register and registered handshake / run-control outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (reset) begin
            state    <= CLEAR;
            ptr      <= '0;
            pend     <= 1'b0;
            checksum <= '0;
            cpu_run  <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            pend     <= pend_next;
            checksum <= checksum_next;
            // Released one cycle after RUN is entered; dropped on the same
            // edge that enters LOAD, so it is never high in CLEAR or LOAD.
            cpu_run  <= (state == RUN) && !bus.load_req;
            in_ready <= (state_next == LOAD);
        end
    end

    assign bus.cpu_run  = cpu_run;
    assign bus.in_ready = in_ready;
    assign bus.busy     = (state != RUN);
    assign bus.checksum = checksum;

    prog_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(ptr),
        .wdata(wdata),
        .raddr(bus.adr),
        .rdata(bus.dout)
    );

endmodule

// File: tb/tb_prog_mem_loader.sv
// Scoreboard bench for prog_mem_loader: stimulus pushes expected read data and
// checksums into queues; a negedge monitor pops and compares them.
module tb_prog_mem_loader;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;

    prog_mem_loader_if bus ();

    prog_mem_loader dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         addr;
        logic [7:0] exp;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [7:0] cks_q[$];
    logic [7:0] model_mem[16];
    logic [7:0] bytes_v[16];
    int         checks = 0;
    int         errors = 0;
    logic       probe  = 1'b0;
    logic       run_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: checksum is the plain byte sum reduced mod 256.
    function automatic logic [7:0] model_sum(input logic [7:0] b[16]);
        int s = 0;
        for (int i = 0; i < 16; i++) s += int'(b[i]);
        return 8'(s % 256);
    endfunction

    // Monitor: compares probed reads, checksum at each CPU release, and the
    // run-while-busy invariant.
    always @(negedge clk) begin
        rd_exp_t e;
        if (probe) begin
            if (rd_q.size() == 0) begin
                check("rd_q_underflow", 1, 0);
            end else begin
                e = rd_q.pop_front();
                check($sformatf("dout[%0d]", e.addr), {24'd0, bus.dout}, {24'd0, e.exp});
            end
        end
        if (bus.cpu_run === 1'b1 && run_prev !== 1'b1) begin
            if (cks_q.size() == 0) check("cks_q_underflow", 1, 0);
            else check("checksum_at_release", {24'd0, bus.checksum}, {24'd0, cks_q.pop_front()});
        end
        if (bus.cpu_run === 1'b1) check("run_while_busy", {31'd0, bus.busy}, 0);
        run_prev = bus.cpu_run;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model_mem[i] = NOP;
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        check("rst_busy", {31'd0, bus.busy}, 1);
        check("rst_cpu_run", {31'd0, bus.cpu_run}, 0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 0);
        check("rst_checksum", {24'd0, bus.checksum}, 0);
        clear_model();
    endtask

    // Release reset and time the CLEAR sweep up to CPU release.
    task automatic release_and_wait();
        int n = 0;
        int busy_fall = -1;
        int run_rise = -1;
        reset = 1'b0;
        bus.load_req = 1'b0;
        while (n < 60 && run_rise < 0) begin
            tick();
            n++;
            if (busy_fall < 0 && bus.busy === 1'b0) busy_fall = n;
            if (bus.cpu_run === 1'b1) run_rise = n;
        end
        check("busy_fall_edge", busy_fall, 16);
        check("run_rise_edge", run_rise, 17);
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) begin
            bus.adr = ADDR_W'(a);
            rd_q.push_back('{a, model_mem[a]});
            probe = 1'b1;
            tick();
        end
        probe = 1'b0;
    endtask

    task automatic start_load();
        bus.load_req = 1'b1;
        tick();
        bus.load_req = 1'b0;
        check("load_cpu_run_drop", {31'd0, bus.cpu_run}, 0);
        check("load_in_ready", {31'd0, bus.in_ready}, 1);
        check("load_busy", {31'd0, bus.busy}, 1);
    endtask

    // mode 0: back-to-back, 1: valid toggles 1-0-1, 2: random valid and load_req
    task automatic stream(input int mode, input int max_bytes, output int cyc, output bit drop);
        int  k = 0;
        bit  acc;
        cyc  = 0;
        drop = 1'b0;
        while (k < max_bytes && cyc < 200) begin
            case (mode)
                0:       bus.in_valid = 1'b1;
                1:       bus.in_valid = (cyc % 2 == 0);
                default: begin
                    bus.in_valid = 1'($urandom_range(0, 1));
                    bus.load_req = 1'($urandom_range(0, 1));
                end
            endcase
            bus.in_data = bytes_v[k];
            if (bus.in_ready !== 1'b1) drop = 1'b1;
            acc = bus.in_valid && (bus.in_ready === 1'b1);
            tick();
            if (acc) k++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.load_req = 1'b0;
        if (k < max_bytes) check("stream_timeout", k, max_bytes);
    endtask

    task automatic finish_load();
        cks_q.push_back(model_sum(bytes_v));
        for (int i = 0; i < 16; i++) model_mem[i] = bytes_v[i];
        check("done_in_ready", {31'd0, bus.in_ready}, 0);
        check("done_cpu_run_low", {31'd0, bus.cpu_run}, 0);
        check("done_busy", {31'd0, bus.busy}, 0);
        tick();
        check("done_cpu_run_high", {31'd0, bus.cpu_run}, 1);
    endtask

    task automatic full_load(input int mode, output int cyc, output bit drop);
        start_load();
        stream(mode, 16, cyc, drop);
        finish_load();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  drop;
        int  n;
        bit  seen_run;

        bus.adr      = '0;
        bus.load_req = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Power-up: CLEAR sweep then release with checksum 0.
        cks_q.push_back(8'h00);
        apply_reset(3);
        release_and_wait();
        read_all();

        // Back-to-back load of the reference program.
        for (int i = 0; i < 16; i++) bytes_v[i] = 8'h00;
        bytes_v[0] = 8'hA3;
        bytes_v[1] = 8'h90;
        full_load(0, cyc, drop);
        check("b2b_cycles", cyc, 16);
        check("b2b_ready_drop", {31'd0, drop}, 0);
        check("b2b_checksum", {24'd0, bus.checksum}, 32'h33);
        read_all();

        // Same program, valid toggling every cycle.
        full_load(1, cyc, drop);
        check("toggle_cycles", cyc, 31);
        check("toggle_ready_drop", {31'd0, drop}, 0);
        read_all();

        // Checksum wrap.
        for (int i = 0; i < 16; i++) bytes_v[i] = 8'hFF;
        full_load(0, cyc, drop);
        check("ff_checksum", {24'd0, bus.checksum}, 32'hF0);
        read_all();

        // Random programs, random gaps, load_req noise during LOAD, stray bytes in RUN.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 16; i++) bytes_v[i] = 8'($urandom);
            full_load(2, cyc, drop);
            check("rand_ready_drop", {31'd0, drop}, 0);
            for (int j = 0; j < 4; j++) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 8'($urandom);
                tick();
                check("run_in_ready", {31'd0, bus.in_ready}, 0);
            end
            bus.in_valid = 1'b0;
            read_all();
        end

        // load_req during CLEAR is held and taken right after the sweep.
        cks_q.push_back(8'h00);
        cks_q.pop_back();
        apply_reset(2);
        reset = 1'b0;
        n = 0;
        seen_run = 1'b0;
        while (n < 60 && bus.in_ready !== 1'b1) begin
            bus.load_req = (n == 5);
            tick();
            n++;
            if (bus.cpu_run === 1'b1) seen_run = 1'b1;
        end
        bus.load_req = 1'b0;
        check("pend_load_edge", n, 16);
        check("pend_no_run", {31'd0, seen_run}, 0);
        for (int i = 0; i < 16; i++) bytes_v[i] = 8'($urandom);
        stream(0, 16, cyc, drop);
        finish_load();
        read_all();

        // Reset after 7 bytes, with load_req high alongside reset (dropped).
        for (int i = 0; i < 16; i++) bytes_v[i] = 8'($urandom_range(1, 255));
        start_load();
        stream(0, 7, cyc, drop);
        bus.load_req = 1'b1;
        cks_q.push_back(8'h00);
        apply_reset(2);
        release_and_wait();
        read_all();

        check("rd_q_empty", rd_q.size(), 0);
        check("cks_q_empty", cks_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
